// File: rtl/riscv_core_wb_lsu_t.sv
`default_nettype none
// ============================================================================
// Module   : riscv_core_wb_lsu_t
// Purpose  : Writeback stage with late-load wait, sub-word load extraction,
//            bounded load timeout with exception pulse, registered forwarding
//            copy of the last register write and a retirement counter.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_core_wb_lsu_t #(
  parameter int XLEN      = 32,
  parameter int RA_W      = 5,
  parameter int TIMEOUT   = 16,
  parameter int RET_CNT_W = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       ACT,
  input  logic [XLEN-1:0]            r_wb_alu_Q,
  input  logic [XLEN-1:0]            r_wb_pc_Q,
  input  logic [RA_W-1:0]            r_wb_rd_Q,
  input  logic                       r_wb_regwrite_Q,
  input  logic [1:0]                 r_wb_rfwt_sel_Q,
  input  logic [2:0]                 r_wb_memsize_Q,
  input  logic [$clog2(XLEN/8)-1:0]  r_wb_memoff_Q,
  input  logic                       mem_rvalid,
  input  logic [XLEN-1:0]            mem_rdata,
  input  logic                       mem_rerr,
  output logic [XLEN-1:0]            rf_xpr_wrt0_D,
  output logic [RA_W-1:0]            rf_xpr_wrt0_WA,
  output logic                       rf_xpr_wrt0_WE,
  output logic                       s_wb_stall_D,
  output logic                       fwd_valid,
  output logic [RA_W-1:0]            fwd_rd,
  output logic [XLEN-1:0]            fwd_data,
  output logic                       wb_exc,
  output logic                       wb_retired,
  output logic [RET_CNT_W-1:0]       retire_cnt
);

  localparam int                 c_OFF_W = $clog2(XLEN/8);
  localparam int                 c_CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT - 1);
  localparam logic [1:0]         c_SEL_ALU  = 2'd0;
  localparam logic [1:0]         c_SEL_LINK = 2'd1;
  localparam logic [1:0]         c_SEL_LOAD = 2'd2;

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_WAIT_MEM = 1'b1
  } state_t;

  state_t                 r_state;
  logic [c_CNT_W-1:0]     r_cnt;
  logic                   r_fwd_valid;
  logic [RA_W-1:0]        r_fwd_rd;
  logic [XLEN-1:0]        r_fwd_data;
  logic                   r_exc;
  logic                   r_retired;
  logic [RET_CNT_W-1:0]   r_ret_cnt;

  logic [c_OFF_W+2:0]     w_shamt;
  logic [XLEN-1:0]        w_shifted;
  logic signed [7:0]      w_sb;
  logic signed [15:0]     w_sh;
  logic signed [31:0]     w_sw;
  logic [XLEN-1:0]        w_load;
  logic [XLEN-1:0]        w_result;
  logic                   w_is_load;
  logic                   w_fire;
  logic                   w_err;
  logic                   w_ok;
  logic                   w_we;
  logic                   w_timeout;
  logic                   w_stall;

  // Align the addressed bytes to bit 0 and extend according to funct3
  always_comb begin
    w_shamt   = {r_wb_memoff_Q, 3'b000};
    w_shifted = mem_rdata >> w_shamt;
    w_sb      = w_shifted[7:0];
    w_sh      = w_shifted[15:0];
    w_sw      = w_shifted[31:0];
    case (r_wb_memsize_Q)
      3'd0:    w_load = XLEN'(w_sb);
      3'd1:    w_load = XLEN'(w_sh);
      3'd3:    w_load = w_shifted;
      3'd4:    w_load = XLEN'(w_shifted[7:0]);
      3'd5:    w_load = XLEN'(w_shifted[15:0]);
      3'd6:    w_load = XLEN'(w_shifted[31:0]);
      default: w_load = XLEN'(w_sw);
    endcase
  end

  // Writeback source selection
  always_comb begin
    case (r_wb_rfwt_sel_Q)
      c_SEL_ALU:  w_result = r_wb_alu_Q;
      c_SEL_LINK: w_result = r_wb_pc_Q + XLEN'(4);
      c_SEL_LOAD: w_result = w_load;
      default:    w_result = '0;
    endcase
  end

  // Fire / stall / abort decisions; inputs are held by upstream while waiting
  always_comb begin
    w_is_load = (r_wb_rfwt_sel_Q == c_SEL_LOAD);
    w_fire    = 1'b0;
    w_stall   = 1'b0;
    w_timeout = 1'b0;
    if (r_state == S_IDLE) begin
      w_fire  = ACT && (!w_is_load || mem_rvalid);
      w_stall = ACT && w_is_load && !mem_rvalid;
    end else begin
      w_fire    = mem_rvalid;
      w_stall   = !mem_rvalid && (r_cnt != c_LAST);
      w_timeout = !mem_rvalid && (r_cnt == c_LAST);
    end
    w_err = w_fire && w_is_load && mem_rerr;
    w_ok  = w_fire && !w_err;
    w_we  = w_ok && r_wb_regwrite_Q && (r_wb_rd_Q != '0);
  end

  // Load-wait state machine with timeout counter
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ACT && w_is_load && !mem_rvalid) begin
            r_state <= S_WAIT_MEM;
            r_cnt   <= c_CNT_W'(1);
          end
        end
        default: begin
          if (mem_rvalid || w_timeout) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Registered forwarding copy, exception/retire pulses and retire counter
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_fwd_valid <= 1'b0;
      r_fwd_rd    <= '0;
      r_fwd_data  <= '0;
      r_exc       <= 1'b0;
      r_retired   <= 1'b0;
      r_ret_cnt   <= '0;
    end else begin
      r_fwd_valid <= w_we;
      if (w_we) begin
        r_fwd_rd   <= r_wb_rd_Q;
        r_fwd_data <= w_result;
      end
      r_exc     <= w_err || w_timeout;
      r_retired <= w_ok;
      if (w_ok) begin
        r_ret_cnt <= r_ret_cnt + RET_CNT_W'(1);
      end
    end
  end

  assign rf_xpr_wrt0_D  = w_result;
  assign rf_xpr_wrt0_WA = r_wb_rd_Q;
  assign rf_xpr_wrt0_WE = w_we;
  assign s_wb_stall_D   = w_stall;
  assign fwd_valid      = r_fwd_valid;
  assign fwd_rd         = r_fwd_rd;
  assign fwd_data       = r_fwd_data;
  assign wb_exc         = r_exc;
  assign wb_retired     = r_retired;
  assign retire_cnt     = r_ret_cnt;

endmodule
`default_nettype wire

// File: tb/tb_riscv_core_wb_lsu_t.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_core_wb_lsu_t
// Purpose  : Self-checking bench for the writeback/load stage: directed cases
//            followed by randomized instructions against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_core_wb_lsu_t;

  localparam int XLEN      = 32;
  localparam int RA_W      = 5;
  localparam int TIMEOUT   = 16;
  localparam int RET_CNT_W = 4;
  localparam int NEVER     = 99;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              ACT = 1'b0;
  logic [XLEN-1:0]   alu = '0;
  logic [XLEN-1:0]   pc = '0;
  logic [RA_W-1:0]   rd = '0;
  logic              regwrite = 1'b0;
  logic [1:0]        sel = '0;
  logic [2:0]        memsize = '0;
  logic [1:0]        memoff = '0;
  logic              mem_rvalid = 1'b0;
  logic [XLEN-1:0]   mem_rdata = '0;
  logic              mem_rerr = 1'b0;
  logic [XLEN-1:0]   wd;
  logic [RA_W-1:0]   wa;
  logic              we;
  logic              stall;
  logic              fwd_valid;
  logic [RA_W-1:0]   fwd_rd;
  logic [XLEN-1:0]   fwd_data;
  logic              wb_exc;
  logic              wb_retired;
  logic [RET_CNT_W-1:0] retire_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  logic [RET_CNT_W-1:0] m_cnt;
  logic [RA_W-1:0]      m_fwd_rd;
  logic [XLEN-1:0]      m_fwd_data;

  riscv_core_wb_lsu_t #(
    .XLEN(XLEN), .RA_W(RA_W), .TIMEOUT(TIMEOUT), .RET_CNT_W(RET_CNT_W)
  ) dut (
    .CLK(CLK), .RST(RST), .ACT(ACT),
    .r_wb_alu_Q(alu), .r_wb_pc_Q(pc), .r_wb_rd_Q(rd),
    .r_wb_regwrite_Q(regwrite), .r_wb_rfwt_sel_Q(sel),
    .r_wb_memsize_Q(memsize), .r_wb_memoff_Q(memoff),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rerr(mem_rerr),
    .rf_xpr_wrt0_D(wd), .rf_xpr_wrt0_WA(wa), .rf_xpr_wrt0_WE(we),
    .s_wb_stall_D(stall), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .wb_exc(wb_exc), .wb_retired(wb_retired),
    .retire_cnt(retire_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Load value: byte-lane select then sign/zero extension by arithmetic
  function automatic logic [31:0] ref_load(input logic [31:0] raw, input logic [2:0] sz,
                                           input logic [1:0] off);
    logic [31:0] v;
    v = raw >> (32'(off) * 8);
    case (sz)
      3'd0:    return ((v & 32'hFF) ^ 32'h80) - 32'h80;
      3'd1:    return ((v & 32'hFFFF) ^ 32'h8000) - 32'h8000;
      3'd4:    return v & 32'hFF;
      3'd5:    return v & 32'hFFFF;
      default: return v;
    endcase
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] s, input logic [31:0] a,
                                             input logic [31:0] p, input logic [31:0] raw,
                                             input logic [2:0] sz, input logic [1:0] off);
    case (s)
      2'd0:    return a;
      2'd1:    return p + 32'd4;
      2'd2:    return ref_load(raw, sz, off);
      default: return 32'd0;
    endcase
  endfunction

  // One instruction; lat = cycle index at which load data arrives (>=TIMEOUT: never)
  task automatic run_instr(input logic [1:0] s, input logic [31:0] a, input logic [31:0] p,
                           input logic [4:0] d, input logic rw, input logic [2:0] sz,
                           input logic [1:0] off, input logic [31:0] raw, input logic err,
                           input int lat);
    int          last;
    logic        is_load;
    logic        ok;
    logic        exp_we;
    logic [31:0] res;
    is_load = (s == 2'd2);
    if (!is_load)               last = 0;
    else if (lat <= TIMEOUT-1)  last = lat;
    else                        last = TIMEOUT-1;
    ok     = !is_load || ((lat <= TIMEOUT-1) && !err);
    res    = ref_result(s, a, p, raw, sz, off);
    exp_we = ok && rw && (d != 5'd0);
    for (int k = 0; k <= last; k++) begin
      @(negedge CLK);
      ACT = 1'b1; sel = s; alu = a; pc = p; rd = d; regwrite = rw;
      memsize = sz; memoff = off;
      if (is_load) begin
        mem_rvalid = (k == lat);
        mem_rdata  = (k == lat) ? raw : $urandom;
        mem_rerr   = (k == lat) ? err : 1'($urandom);
      end else begin
        mem_rvalid = 1'($urandom);
        mem_rdata  = $urandom;
        mem_rerr   = 1'($urandom);
      end
      #1;
      if (k < last) begin
        chk("stall_wait", stall, 1);
        chk("we_wait", we, 0);
      end else begin
        chk("stall_end", stall, 0);
        chk("we", we, exp_we);
        if (exp_we) begin
          chk("wa", wa, d);
          chk("wd", wd, res);
        end
      end
      @(posedge CLK); #1;
      if (k < last) begin
        chk("fwd_valid_wait", fwd_valid, 0);
        chk("retired_wait", wb_retired, 0);
        chk("exc_wait", wb_exc, 0);
      end
    end
    if (ok) m_cnt = m_cnt + 1'b1;
    if (exp_we) begin
      m_fwd_rd   = d;
      m_fwd_data = res;
    end
    chk("fwd_valid", fwd_valid, exp_we);
    chk("fwd_rd", fwd_rd, m_fwd_rd);
    chk("fwd_data", fwd_data, m_fwd_data);
    chk("wb_exc", wb_exc, !ok);
    chk("wb_retired", wb_retired, ok);
    chk("retire_cnt", retire_cnt, m_cnt);
  endtask

  // Bubble cycle: stray mem_rvalid must be ignored
  task automatic idle_cycle();
    @(negedge CLK);
    ACT = 1'b0; sel = 2'($urandom); mem_rvalid = 1'($urandom); mem_rerr = 1'($urandom);
    mem_rdata = $urandom;
    #1;
    chk("idle_stall", stall, 0);
    chk("idle_we", we, 0);
    @(posedge CLK); #1;
    chk("idle_fwd_valid", fwd_valid, 0);
    chk("idle_retired", wb_retired, 0);
    chk("idle_exc", wb_exc, 0);
    chk("idle_cnt", retire_cnt, m_cnt);
  endtask

  task automatic model_reset();
    m_cnt = '0; m_fwd_rd = '0; m_fwd_data = '0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_we", we, 0);
    chk("rst_fwd_valid", fwd_valid, 0);
    chk("rst_cnt", retire_cnt, 0);
    @(negedge CLK); RST = 1'b1;

    // Directed cases
    run_instr(2'd0, 32'h1234, 32'h0, 5'd5, 1'b1, 3'd0, 2'd0, 32'h0, 1'b0, 0);
    run_instr(2'd1, 32'h0, 32'hFFFF_FFFC, 5'd1, 1'b1, 3'd0, 2'd0, 32'h0, 1'b0, 0);
    run_instr(2'd0, 32'hDEAD, 32'h0, 5'd0, 1'b1, 3'd0, 2'd0, 32'h0, 1'b0, 0);
    run_instr(2'd2, 32'h0, 32'h0, 5'd7, 1'b1, 3'd0, 2'd2, 32'h0080_0000, 1'b0, 3);
    run_instr(2'd2, 32'h0, 32'h0, 5'd8, 1'b1, 3'd4, 2'd2, 32'h0080_0000, 1'b0, 0);
    run_instr(2'd2, 32'h0, 32'h0, 5'd9, 1'b1, 3'd1, 2'd2, 32'h8001_0000, 1'b0, 1);
    run_instr(2'd2, 32'h0, 32'h0, 5'd9, 1'b1, 3'd1, 2'd2, 32'h8001_0000, 1'b1, 0);
    idle_cycle();
    run_instr(2'd2, 32'h0, 32'h0, 5'd10, 1'b1, 3'd2, 2'd0, 32'h0, 1'b0, NEVER);
    run_instr(2'd2, 32'h0, 32'h0, 5'd11, 1'b1, 3'd2, 2'd0, 32'hCAFE_F00D, 1'b0, TIMEOUT-1);
    run_instr(2'd0, 32'h5555, 32'h0, 5'd12, 1'b1, 3'd0, 2'd0, 32'h0, 1'b0, 0);
    run_instr(2'd3, 32'h5555, 32'h0, 5'd13, 1'b1, 3'd0, 2'd0, 32'h0, 1'b0, 0);

    // Randomized instructions
    for (int i = 0; i < 80; i++) begin
      int r;
      int lat;
      r   = int'($urandom_range(0, 9));
      lat = (r == 9) ? NEVER : ((r >= 6) ? 0 : r);
      run_instr(2'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom_range(0, 3) != 0),
                3'($urandom), 2'($urandom), $urandom, ($urandom_range(0, 7) == 0), lat);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    // Reset in the middle of a load wait
    @(negedge CLK);
    ACT = 1'b1; sel = 2'd2; rd = 5'd3; regwrite = 1'b1; mem_rvalid = 1'b0;
    @(posedge CLK); @(posedge CLK); #2;
    RST = 1'b0; ACT = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_we", we, 0);
    chk("mid_rst_fwd_valid", fwd_valid, 0);
    chk("mid_rst_fwd_rd", fwd_rd, 0);
    chk("mid_rst_fwd_data", fwd_data, 0);
    chk("mid_rst_exc", wb_exc, 0);
    chk("mid_rst_retired", wb_retired, 0);
    chk("mid_rst_cnt", retire_cnt, 0);
    @(negedge CLK); RST = 1'b1;
    idle_cycle();

    // Counter wrap after 2^RET_CNT_W retirements
    for (int i = 0; i < 16; i++) begin
      run_instr(2'd0, $urandom, 32'h0, 5'($urandom), 1'b1, 3'd0, 2'd0, 32'h0, 1'b0, 0);
    end
    chk("cnt_wrap", retire_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
